// File: rtl/pw_pkg.sv
// Shared types and sizing for the password checker.
package pw_pkg;

   localparam int unsigned DIGIT_W              = 4;
   localparam int unsigned ENTRY_DEPTH          = 4;
   localparam int unsigned BUF_W                = DIGIT_W * ENTRY_DEPTH;
   localparam int unsigned LEN_W                = 3;
   localparam int unsigned DEFAULT_MAX_ATTEMPTS = 3;

   typedef enum logic [2:0] {
      StEntry,
      StCheck,
      StWrong,
      StLockout,
      StRelease,
      StOpen
   } pw_state_e;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/entry_shift_reg.sv
// Digit buffer for the password checker: shifts BCD digits in at the low end
// and tracks how many are held. Clear has priority over shift.
module entry_shift_reg
   import pw_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               shift_i,
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [BUF_W-1:0]   entry_o,
   output logic [LEN_W-1:0]   len_o
);

   logic [BUF_W-1:0] entry_q, entry_d;
   logic [LEN_W-1:0] len_q, len_d;

   always_comb begin
      entry_d = entry_q;
      len_d   = len_q;
      if (clr_i) begin
         entry_d = '0;
         len_d   = '0;
      end else if (shift_i && (len_q < LEN_W'(ENTRY_DEPTH))) begin
         entry_d = {entry_q[BUF_W-DIGIT_W-1:0], digit_i};
         len_d   = len_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entry_q <= '0;
         len_q   <= '0;
      end else begin
         entry_q <= entry_d;
         len_q   <= len_d;
      end
   end

   assign entry_o = entry_q;
   assign len_o   = len_q;

endmodule

// File: rtl/password_check.sv
// Keypad password checker with attempt counting, lockout and flag handshake.
// Define PASSWORD_CHECK_TIMEOUT_EN to discard a partial entry after TIMEOUT_CYCLES idle cycles.
module password_check
   import pw_pkg::*;
#(
   parameter logic [BUF_W-1:0] PASSWORD       = 16'h1234,
   parameter int unsigned      MAX_ATTEMPTS   = DEFAULT_MAX_ATTEMPTS,
   parameter int unsigned      TIMEOUT_CYCLES = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               enter,
   input  logic               flag_resolve,
   input  logic               locker,
   output logic               flag,
   output logic               flag_select,
   output logic               lock,
   output logic [1:0]         attempts,
   output logic [LEN_W-1:0]   entry_len
);

   localparam logic [2:0] MaxAtt = 3'(MAX_ATTEMPTS);

   pw_state_e        state_q, state_d;
   logic [1:0]       attempts_q, attempts_d;
   logic             flag_q, flag_d;
   logic             flag_select_q, flag_select_d;
   logic             lock_q, lock_d;
   logic [2:0]       attempts_inc;
   logic             accept;
   logic             clr;
   logic             tmo_hit;
   logic [BUF_W-1:0] entry_buf;

   // enter wins over a simultaneous digit
   assign accept = (state_q == StEntry) && digit_valid && !enter && is_bcd(digit)
                   && (entry_len < LEN_W'(ENTRY_DEPTH));
   assign clr    = (state_q == StCheck) || tmo_hit;

   entry_shift_reg u_entry (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (clr),
      .shift_i (accept),
      .digit_i (digit),
      .entry_o (entry_buf),
      .len_o   (entry_len)
   );

`ifdef PASSWORD_CHECK_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TmoW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d   = '0;
      tmo_hit = 1'b0;
      if ((state_q == StEntry) && (entry_len != '0) && !enter && !accept) begin
         if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      attempts_d    = attempts_q;
      attempts_inc  = {1'b0, attempts_q} + 3'd1;
      flag_d        = 1'b0;
      flag_select_d = flag_select_q;
      lock_d        = 1'b1;
      unique case (state_q)
         StEntry: begin
            if ({1'b0, attempts_q} > (MaxAtt - 3'd1)) begin
               attempts_d = 2'(MaxAtt - 3'd1);
            end
            if (enter) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if ((entry_len == LEN_W'(ENTRY_DEPTH)) && (entry_buf == PASSWORD)) begin
               attempts_d = '0;
               state_d    = StOpen;
            end else begin
               attempts_d = attempts_inc[1:0];
               state_d    = (attempts_inc == MaxAtt) ? StLockout : StWrong;
            end
         end
         StWrong: begin
            flag_d        = !flag_resolve;
            flag_select_d = 1'b0;
            if (flag_resolve) begin
               state_d = StRelease;
            end
         end
         StLockout: begin
            flag_d        = !flag_resolve;
            flag_select_d = 1'b1;
            if (flag_resolve) begin
               attempts_d = '0;
               state_d    = StRelease;
            end
         end
         StRelease: begin
            if (!flag_resolve) begin
               state_d = StEntry;
            end
         end
         StOpen: begin
            lock_d = locker;
            if (locker) begin
               state_d = StEntry;
            end
         end
         default: state_d = StEntry;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StEntry;
         attempts_q    <= '0;
         flag_q        <= 1'b0;
         flag_select_q <= 1'b0;
         lock_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         attempts_q    <= attempts_d;
         flag_q        <= flag_d;
         flag_select_q <= flag_select_d;
         lock_q        <= lock_d;
      end
   end

   assign flag        = flag_q;
   assign flag_select = flag_select_q;
   assign lock        = lock_q;
   assign attempts    = attempts_q;

endmodule

// File: tb/tb_password_check.sv
// Bench for password_check: directed table, corner sequences and randomized
// stimulus against a queue-based reference model.
module tb_password_check;

   localparam logic [15:0] PW   = 16'h1234;
   localparam int          MAXA = 3;
   localparam int          TMO  = 10;

   localparam int MD_ENTRY = 0, MD_CHECK = 1, MD_WRONG = 2;
   localparam int MD_LOCK = 3, MD_REL = 4, MD_OPEN = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       enter = 1'b0;
   logic       flag_resolve = 1'b0;
   logic       locker = 1'b0;
   logic       flag, flag_select, lock;
   logic [1:0] attempts;
   logic [2:0] entry_len;

   int nvec = 0;
   int nerr = 0;

   // reference model state
   int m_mode;
   int q[$];
   int m_att, m_tmo;
   bit m_flag, m_fsel, m_lock;

   typedef struct {
      bit dv; logic [3:0] d; bit en; bit res; bit lk;
      bit f; bit fs; bit l; logic [1:0] att; logic [2:0] len;
   } vec_t;
   vec_t tbl[$];

   password_check #(
      .PASSWORD       (PW),
      .MAX_ATTEMPTS   (MAXA),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .enter        (enter),
      .flag_resolve (flag_resolve),
      .locker       (locker),
      .flag         (flag),
      .flag_select  (flag_select),
      .lock         (lock),
      .attempts     (attempts),
      .entry_len    (entry_len)
   );

   always #5 clk = ~clk;

   function automatic int pw_digit(input int i);
      return int'((PW >> (12 - 4 * i)) & 16'hF);
   endfunction

   function automatic void model_reset();
      m_mode = MD_ENTRY; q.delete(); m_att = 0; m_tmo = 0;
      m_flag = 0; m_fsel = 0; m_lock = 1;
   endfunction

   task automatic model_step();
      bit ok;
      m_flag = ((m_mode == MD_WRONG) || (m_mode == MD_LOCK)) && !flag_resolve;
      if (m_mode == MD_WRONG) m_fsel = 0;
      else if (m_mode == MD_LOCK) m_fsel = 1;
      m_lock = (m_mode != MD_OPEN) || locker;
      case (m_mode)
         MD_ENTRY: begin
            if (enter) begin
               m_mode = MD_CHECK; m_tmo = 0;
            end else if (digit_valid && (digit <= 4'd9) && (q.size() < 4)) begin
               q.push_back(int'(digit)); m_tmo = 0;
            end else if (q.size() > 0) begin
`ifdef PASSWORD_CHECK_TIMEOUT_EN
               m_tmo++;
               if (m_tmo == TMO) begin q.delete(); m_tmo = 0; end
`endif
            end
         end
         MD_CHECK: begin
            ok = (q.size() == 4);
            if (ok) for (int i = 0; i < 4; i++) if (q[i] != pw_digit(i)) ok = 0;
            q.delete();
            if (ok) begin
               m_att = 0; m_mode = MD_OPEN;
            end else begin
               m_att++;
               m_mode = (m_att == MAXA) ? MD_LOCK : MD_WRONG;
            end
         end
         MD_WRONG: if (flag_resolve) m_mode = MD_REL;
         MD_LOCK:  if (flag_resolve) begin m_att = 0; m_mode = MD_REL; end
         MD_REL:   if (!flag_resolve) m_mode = MD_ENTRY;
         MD_OPEN:  if (locker) m_mode = MD_ENTRY;
         default:  m_mode = MD_ENTRY;
      endcase
   endtask

   // called at a falling edge; applies inputs for one rising edge
   task automatic cycle(input bit dv, input logic [3:0] d, input bit en, input bit res,
                        input bit lk);
      digit_valid = dv; digit = d; enter = en; flag_resolve = res; locker = lk;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input bit res);
      cycle(0, 4'd0, 0, res, 0);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".flag"},        8'(flag),        8'(m_flag));
      chk({tag, ".flag_select"}, 8'(flag_select), 8'(m_fsel));
      chk({tag, ".lock"},        8'(lock),        8'(m_lock));
      chk({tag, ".attempts"},    8'(attempts),    8'(m_att));
      chk({tag, ".entry_len"},   8'(entry_len),   8'(q.size()));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      digit_valid = 0; enter = 0; flag_resolve = 0; locker = 0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic void add(bit dv, logic [3:0] d, bit en, bit res, bit lk,
                               bit f, bit fs, bit l, int att, int len);
      vec_t v;
      v.dv = dv; v.d = d; v.en = en; v.res = res; v.lk = lk;
      v.f = f; v.fs = fs; v.l = l; v.att = 2'(att); v.len = 3'(len);
      tbl.push_back(v);
   endfunction

   initial begin
      bit res_r;
      // inputs: dv, digit, enter, resolve, locker -> flag, flag_select, lock, attempts, len
      add(1, 4'h1, 0, 0, 0,  0, 0, 1, 0, 1);
      add(1, 4'hA, 0, 0, 0,  0, 0, 1, 0, 1);
      add(1, 4'h2, 0, 0, 0,  0, 0, 1, 0, 2);
      add(1, 4'h3, 0, 0, 0,  0, 0, 1, 0, 3);
      add(1, 4'h4, 0, 0, 0,  0, 0, 1, 0, 4);
      add(1, 4'h9, 0, 0, 0,  0, 0, 1, 0, 4);
      add(0, 4'h0, 1, 0, 0,  0, 0, 1, 0, 4);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 0, 0);
      add(0, 4'h0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 4'h5, 1, 0, 0,  0, 0, 0, 0, 0);
      add(0, 4'h0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 4'h0, 0, 0, 1,  0, 0, 1, 0, 0);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 0, 0);
      add(1, 4'h1, 0, 0, 0,  0, 0, 1, 0, 1);
      add(1, 4'h2, 0, 0, 0,  0, 0, 1, 0, 2);
      add(1, 4'h3, 0, 0, 0,  0, 0, 1, 0, 3);
      add(1, 4'h5, 0, 0, 0,  0, 0, 1, 0, 4);
      add(0, 4'h0, 1, 0, 0,  0, 0, 1, 0, 4);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 1, 0);
      add(0, 4'h0, 0, 0, 0,  1, 0, 1, 1, 0);
      add(0, 4'h0, 0, 0, 0,  1, 0, 1, 1, 0);
      add(0, 4'h0, 0, 1, 0,  0, 0, 1, 1, 0);
      add(0, 4'h0, 0, 1, 0,  0, 0, 1, 1, 0);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 1, 0);
      add(1, 4'h7, 0, 0, 0,  0, 0, 1, 1, 1);
      add(0, 4'h0, 1, 0, 0,  0, 0, 1, 1, 1);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 2, 0);
      add(0, 4'h0, 0, 0, 0,  1, 0, 1, 2, 0);
      add(0, 4'h0, 0, 1, 0,  0, 0, 1, 2, 0);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 2, 0);
      add(0, 4'h0, 1, 0, 0,  0, 0, 1, 2, 0);
      add(0, 4'h0, 0, 0, 0,  0, 0, 1, 3, 0);
      add(0, 4'h0, 0, 0, 0,  1, 1, 1, 3, 0);
      add(0, 4'h0, 0, 1, 0,  0, 1, 1, 0, 0);
      add(0, 4'h0, 0, 0, 0,  0, 1, 1, 0, 0);
      add(1, 4'h3, 0, 0, 0,  0, 1, 1, 0, 1);
      add(0, 4'h0, 0, 0, 1,  0, 1, 1, 0, 1);

      // reset state
      @(negedge clk);
      @(negedge clk);
      model_reset();
      chk_model("reset");
      rst = 1'b0;

      // directed table
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].dv, tbl[i].d, tbl[i].en, tbl[i].res, tbl[i].lk);
         chk($sformatf("tbl%0d.flag", i),        8'(flag),        8'(tbl[i].f));
         chk($sformatf("tbl%0d.flag_select", i), 8'(flag_select), 8'(tbl[i].fs));
         chk($sformatf("tbl%0d.lock", i),        8'(lock),        8'(tbl[i].l));
         chk($sformatf("tbl%0d.attempts", i),    8'(attempts),    8'(tbl[i].att));
         chk($sformatf("tbl%0d.entry_len", i),   8'(entry_len),   8'(tbl[i].len));
      end

      // asynchronous reset while the lockout flag is up
      do_reset();
      for (int k = 0; k < MAXA; k++) begin
         cycle(0, 4'd0, 1, 0, 0);
         idle(0);
         idle(0);
         if (k < MAXA - 1) begin
            idle(1);
            idle(0);
         end
      end
      chk("lockout.flag", 8'(flag), 8'd1);
      chk("lockout.flag_select", 8'(flag_select), 8'd1);
      rst = 1'b1;
      #1;
      chk("async_rst.flag", 8'(flag), 8'd0);
      chk("async_rst.lock", 8'(lock), 8'd1);
      chk("async_rst.attempts", 8'(attempts), 8'd0);
      chk("async_rst.flag_select", 8'(flag_select), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // partial entry left idle, with one failed attempt on record
      cycle(0, 4'd0, 1, 0, 0);
      idle(0);
      idle(0);
      idle(1);
      idle(0);
      cycle(1, 4'd1, 0, 0, 0);
      cycle(1, 4'd2, 0, 0, 0);
      for (int i = 0; i < TMO - 1; i++) idle(0);
      chk("tmo_pre.entry_len", 8'(entry_len), 8'd2);
      idle(0);
`ifdef PASSWORD_CHECK_TIMEOUT_EN
      chk("tmo.entry_len", 8'(entry_len), 8'd0);
`else
      for (int i = 0; i < TMO; i++) idle(0);
      chk("no_tmo.entry_len", 8'(entry_len), 8'd2);
`endif
      chk("tmo.attempts", 8'(attempts), 8'd1);

      // randomized run against the reference model
      do_reset();
      res_r = 0;
      for (int n = 0; n < 3000; n++) begin
         bit dv, en, lk;
         logic [3:0] d;
         dv = ($urandom_range(0, 2) == 0);
         if ((q.size() < 4) && ($urandom_range(0, 1) == 0)) d = 4'(pw_digit(q.size()));
         else d = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) res_r = !res_r;
         lk = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) == 0) begin
            for (int j = 0; j < 12; j++) begin
               idle(res_r);
               chk_model("rnd_idle");
            end
         end
         cycle(dv, d, en, res_r, lk);
         chk_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
